// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared types and constants for the multi-precision add sequencer
package mp_add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed overflow of one addition step, judged on the operand and result sign bits.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - request/result handshake bundle between requester, sequencer and consumer
interface mp_add_seq_if #(
  parameter int WORDS = 4
) ();

  localparam int DW = WORDS * 8;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          op;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic          ovf;
  logic          busy;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/rca8_slice.sv
// rtl/rca8_slice.sv - combinational 8-bit ripple-carry slice built from 1-bit full adders
module rca8_fa1 (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module rca8_slice
  import mp_add_pkg::*;
(
  output logic [SLICE_W-1:0] S,
  output logic               Co,
  input  logic [SLICE_W-1:0] X,
  input  logic [SLICE_W-1:0] Y,
  input  logic               Ci
);

  logic [SLICE_W:0] c;

  assign c[0] = Ci;
  assign Co   = c[SLICE_W];

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    rca8_fa1 u_fa (
      .x  (X[i]),
      .y  (Y[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - byte-serial WORDS*8-bit adder sharing one 8-bit slice, LSB byte first.
// Optional subtract mode (a - b) is built only when SUB_EN is defined.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = $clog2(WORDS)
) (
  input logic          clk,
  input logic          rst,
  mp_add_seq_if.slave  bus
);

  localparam int             DW   = WORDS * SLICE_W;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [DW-1:0]      b_in;
  logic               c_in;
  logic [SLICE_W-1:0] slice_x, slice_y, slice_s;
  logic               slice_co;

`ifdef SUB_EN
  // Subtraction is a + ~b + 1, so cin is replaced rather than combined.
  assign b_in = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  assign c_in = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
`else
  logic unused_op;
  assign unused_op = bus.op;
  assign b_in      = bus.b;
  assign c_in      = bus.cin;
`endif

  assign slice_x = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_y = b_q[idx_q*SLICE_W +: SLICE_W];

  rca8_slice u_slice (
    .S  (slice_s),
    .Co (slice_co),
    .X  (slice_x),
    .Y  (slice_y),
    .Ci (carry_q)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        if (idx_q == LAST) begin
          cout_d  = slice_co;
          ovf_d   = signed_ovf(slice_x[SLICE_W-1], slice_y[SLICE_W-1], slice_s[SLICE_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - self-checking bench for mp_add_seq (WORDS=4), with or without SUB_EN
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int DW    = WORDS * 8;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
  } res_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          op;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mp_add_seq_if #(.WORDS(WORDS)) bus ();

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   rcvd   = 0;
  int   cyc    = 0;
  int   or_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 = held high, 1 = held low, otherwise random.
  always @(posedge clk) begin
    #2;
    case (or_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic cin, input logic op);
    res_t          r;
    logic [DW:0]   full;
    logic          sub;
    sub = 1'b0;
`ifdef SUB_EN
    sub = op;
`endif
    if (sub) begin
      full   = {1'b0, a} - {1'b0, b};
      r.sum  = full[DW-1:0];
      r.cout = (a >= b);
      r.ovf  = (a[DW-1] != b[DW-1]) && (r.sum[DW-1] != a[DW-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
      r.sum  = full[DW-1:0];
      r.cout = full[DW];
      r.ovf  = (a[DW-1] == b[DW-1]) && (r.sum[DW-1] != a[DW-1]);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                              input logic op, input logic [DW-1:0] s, input logic co, input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.op = op;
    v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed output handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      rcvd++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0h with no pending request", bus.sum);
      end else begin
        e = sb_q.pop_front();
        check("result{cout,ovf,sum}", {30'd0, bus.cout, bus.ovf, bus.sum},
              {30'd0, e.cout, e.ovf, e.sum});
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                      input logic op, input res_t exp, input bit push, output int acc_cyc);
    int n;
    bus.a = a; bus.b = b; bus.cin = cin; bus.op = op;
    bus.in_valid = 1'b1;
    n = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", n);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (push) sb_q.push_back(exp);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.cin = 1'($urandom); bus.op = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 || !bus.in_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
        return;
      end
    end
  endtask

  initial begin
    int   acc0, acc1, lat;
    bit   ok;
    res_t cap;
    int   rcvd0;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 1'b0;

    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0));
    vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1));
    vecs.push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0));
    vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1));
    vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0));
`ifdef SUB_EN
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1));
`else
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0101, 1'b0, 1'b0));
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_outputs{cout,ovf,sum}", {30'd0, bus.cout, bus.ovf, bus.sum}, 64'd0);

    // Table vectors, out_ready high: result compared by the scoreboard, latency here.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].exp, 1'b1, acc0);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) begin
          lat = k;
          break;
        end
      end
      check("latency", 64'(lat), 64'(WORDS));
      wait_drain();
    end

    // Back-to-back throughput with out_ready high.
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, model(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0), 1'b1, acc0);
    send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, model(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0), 1'b1, acc1);
    check("throughput_cycles", 64'(acc1 - acc0), 64'(WORDS + 2));
    wait_drain();

    // Back-pressure: result must hold and no request may be taken while DONE.
    or_mode = 1;
    send(32'h7000_0000, 32'h1000_0000, 1'b0, 1'b0, model(32'h7000_0000, 32'h1000_0000, 1'b0, 1'b0), 1'b1, acc0);
    repeat (WORDS) @(posedge clk);
    #1;
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    cap.sum = bus.sum; cap.cout = bus.cout; cap.ovf = bus.ovf;
    check("bp_captured_result", {30'd0, cap.cout, cap.ovf, cap.sum}, {30'd0, 1'b0, 1'b1, 32'h8000_0000});
    bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      ok = (bus.sum == cap.sum) && (bus.cout == cap.cout) && (bus.ovf == cap.ovf) &&
           (bus.in_ready == 1'b0) && (bus.out_valid == 1'b1) && (bus.busy == 1'b1);
      check("bp_hold", 64'(ok), 64'd1);
    end
    bus.in_valid = 1'b0;
    or_mode = 0;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    send(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, model(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0), 1'b1, acc0);
    wait_drain();

    // Reset mid-run: the partial result must vanish.
    rcvd0 = rcvd;
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, model(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0), 1'b0, acc0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ok = 1'b0;
    end
    check("midrst_no_output", 64'(ok), 64'd1);
    check("midrst_no_handshake", 64'(rcvd - rcvd0), 64'd0);
    send(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, model(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0), 1'b1, acc0);
    wait_drain();

    // Random back-to-back requests with random out_ready.
    or_mode = 2;
    rcvd0 = rcvd;
    for (int i = 0; i < 100; i++) begin
      logic [DW-1:0] ra, rb;
      logic          rc, ro;
      ra = $urandom; rb = $urandom;
      if (i % 10 == 0) ra = '1;
      if (i % 10 == 5) rb = 32'h8000_0000;
      rc = 1'($urandom); ro = 1'($urandom);
      send(ra, rb, rc, ro, model(ra, rb, rc, ro), 1'b1, acc0);
    end
    wait_drain();
    or_mode = 0;
    check("random_count", 64'(rcvd - rcvd0), 64'd100);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add sequencer that time-shares a single 8-bit ripple-carry slice across a WORDS×8-bit operand pair.
- Processes one byte per cycle, LSB byte first, with the carry registered between bytes.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out), replacing a wide combinational adder where area matters more than latency.

Parameters:
- WORDS, 4, number of 8-bit slices per operand (legal 2..16); operand width DW = WORDS*8
- IDXW, $clog2(WORDS), width of the byte-index counter (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- a  in  DW  operand A, sampled on accept
- b  in  DW  operand B, sampled on accept
- cin  in  1  carry-in to byte 0, sampled on accept
- op  in  1  0=add, 1=subtract; sampled on accept; ignored unless SUB_EN is defined
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  DW  result
- cout  out  1  carry out of the top byte
- ovf  out  1  signed two's-complement overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, carry reg=0. Outputs: sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 as soon as rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: latch a, b (b inverted when subtracting), carry=cin (forced to 1 when subtracting), idx=0, sum cleared; go to RUN.
- RUN:
  - Each cycle the slice computes a[idx], b'[idx], carry → S, Co.
  - sum byte idx ← S; carry ← Co; idx ← idx+1.
  - When idx==WORDS-1: cout ← Co, ovf ← (a_msb==b'_msb) && (S_msb!=a_msb); go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
  - No new accept while in DONE.
- Latency: out_valid rises exactly WORDS cycles after the accept edge. Throughput is one result per WORDS+2 cycles with out_ready tied high.
- Back-pressure: out_valid may stay high indefinitely; in_ready stays 0 for the whole time.
- Back-to-back: in_ready reasserts the cycle after the output handshake.
- Inputs a, b, cin and op are don't-care outside the accept cycle.
- Reset mid-operation (RUN or DONE): immediate return to reset values; the partial result is discarded and no out_valid is produced.
- idx never wraps; it is only meaningful in RUN.
- Sum arithmetic is modulo 2^DW. cout follows unsigned-add semantics; in subtract mode cout=1 means no borrow.

Optional Feature:
- Macro SUB_EN.
- Defined: op=1 latches ~b and forces the initial carry to 1, so the result is a−b. cin is ignored for subtract.
- Not defined: op is ignored, the block always computes a+b+cin, and the inversion logic is not synthesised.

Decomposition:
- Shared package mp_add_pkg holds:
  - SLICE_W=8
  - state enum {IDLE, RUN, DONE}
  - OP_ADD / OP_SUB constants
- One sub-module, rca8_slice: combinational 8-bit ripple-carry slice built from 1-bit full adders; ports S[7:0], Co, X[7:0], Y[7:0], Ci.
- mp_add_seq holds all sequential state: operand regs, sum reg, carry reg, idx, FSM.

Test Plan:
- WORDS=4, a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0, cout=1, ovf=0.
- a=32'h7FFF_FFFF, b=1, cin=0 → sum=32'h8000_0000, cout=0, ovf=1. a=32'h1234_5678, b=32'h1111_1111, cin=1 → sum=32'h2345_678A, cout=0.
- out_ready held 0 for 10 cycles after out_valid → sum, cout and ovf stable and in_ready=0 throughout; release → in_ready=1 next cycle; second request accepted.
- rst pulsed 2 cycles after accept → busy=0, out_valid never asserts for that request; the next request returns its correct sum.
- SUB_EN defined: op=1, a=5, b=7 → sum=32'hFFFF_FFFE, cout=0. a=7, b=5 → sum=2, cout=1.
- 100 random back-to-back requests with random out_ready → every result equals the a+b+cin model (or a−b under SUB_EN), in order, none dropped or duplicated.
